// File: rtl/uart_rx_monitor.sv
// UART receive monitor: 2-FF synchroniser, frame FSM (start/data/parity/stop/break),
// FWFT character FIFO with valid/ready pop, and sticky framing/parity/overrun flags.
// Optional simulation printout of received characters and error events is compiled in
// when UART_RX_MONITOR_PRINT_EN is defined; without it the module is purely synthesizable.
module uart_rx_monitor #(
  parameter int unsigned BAUD_DIV   = 280,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst,
  input  logic                          i_rx,
  output logic [DATA_BITS-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_busy,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_overrun,
  input  logic                          i_clr_err
);

  localparam int unsigned TimW = $clog2(BAUD_DIV + 1);
  localparam int unsigned CntW = $clog2(DATA_BITS);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e state_q, state_d;

  // Synchroniser and edge-detect history
  logic rx_meta_q, rx_s_q, rx_prev_q;

  // Bit timing and frame datapath
  logic [TimW-1:0]      timer_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_acc_q;
  logic                 bad_q;
  logic                 push_q;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;

  // Sticky flags
  logic frame_err_q, parity_err_q, overrun_q;

  // Decoded control
  logic fall, tick, last_bit, last_stop, par_bad;
  logic load_half, timer_run, shift_en, stop_adv;
  logic set_perr, set_ferr, push_set;
  logic full, empty, pop, push_ok, set_ovr;

  assign fall      = rx_prev_q & ~rx_s_q;
  assign tick      = (timer_q == TimW'(1));
  assign last_bit  = (bit_cnt_q == CntW'(DATA_BITS - 1));
  assign last_stop = (STOP_BITS == 1) || stop_cnt_q;
  // Odd parity wants an overall XOR of 1, even parity wants 0.
  assign par_bad   = (PARITY == 1) ? ~(par_acc_q ^ rx_s_q) : (par_acc_q ^ rx_s_q);

  // Two-flop synchroniser; idles high so reset does not look like a start edge
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (fall) state_d = StStart;
      StStart:  if (tick) state_d = rx_s_q ? StIdle : StData;
      StData:   if (tick && last_bit) state_d = (PARITY != 0) ? StParity : StStop;
      StParity: if (tick) state_d = StStop;
      StStop: begin
        if (tick) begin
          if (!rx_s_q) begin
            state_d = StBreak;
          end else if (last_stop) begin
            state_d = StIdle;
          end
        end
      end
      StBreak:  if (rx_s_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: datapath strobes, error events and busy
  always_comb begin
    load_half = 1'b0;
    timer_run = 1'b0;
    shift_en  = 1'b0;
    stop_adv  = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    push_set  = 1'b0;
    case (state_q)
      StIdle:   load_half = fall;
      StStart:  timer_run = 1'b1;
      StData: begin
        timer_run = 1'b1;
        shift_en  = tick;
      end
      StParity: begin
        timer_run = 1'b1;
        set_perr  = tick & par_bad;
      end
      StStop: begin
        timer_run = 1'b1;
        if (tick) begin
          if (!rx_s_q) begin
            set_ferr = 1'b1;
          end else if (last_stop) begin
            push_set = ~bad_q;
          end else begin
            stop_adv = 1'b1;
          end
        end
      end
      default: ;
    endcase
    o_busy = (state_q != StIdle);
  end

  // Bit timer, shift register, parity accumulator and push strobe
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      par_acc_q  <= 1'b0;
      bad_q      <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      push_q <= push_set;
      if (load_half) begin
        // First sample lands mid start bit
        timer_q    <= TimW'(BAUD_DIV / 2);
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        par_acc_q  <= 1'b0;
        bad_q      <= 1'b0;
      end else if (timer_run) begin
        timer_q <= tick ? TimW'(BAUD_DIV) : timer_q - TimW'(1);
      end else begin
        timer_q <= '0;
      end
      if (shift_en) begin
        shreg_q   <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
        par_acc_q <= par_acc_q ^ rx_s_q;
        bit_cnt_q <= bit_cnt_q + CntW'(1);
      end
      if (set_perr) bad_q <= 1'b1;
      if (stop_adv) stop_cnt_q <= 1'b1;
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign full    = (o_count == (AW + 1)'(FIFO_DEPTH));
  assign o_valid = ~empty;
  assign pop     = o_valid & i_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_q & (~full | pop);
  assign set_ovr = push_q & full & ~pop;
  assign o_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // FIFO pointers; the extra MSB separates full from empty
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge wb_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= set_ferr | (frame_err_q & ~i_clr_err);
      parity_err_q <= set_perr | (parity_err_q & ~i_clr_err);
      overrun_q    <= set_ovr | (overrun_q & ~i_clr_err);
    end
  end

  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overrun    = overrun_q;

`ifdef UART_RX_MONITOR_PRINT_EN
  // Simulation console: echo characters and announce newly raised error flags
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      if (push_ok) $write("%c", shreg_q);
      if (set_ferr && !frame_err_q) $display("[%0t] uart_rx_monitor: framing error", $time);
      if (set_perr && !parity_err_q) $display("[%0t] uart_rx_monitor: parity error", $time);
      if (set_ovr && !overrun_q) $display("[%0t] uart_rx_monitor: FIFO overrun", $time);
    end
  end
`else
  // Console echo disabled
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor configured 8E1, 16 clocks per bit, 4-entry FIFO.
module tb_uart_rx_monitor;

  localparam int unsigned Baud  = 16;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [2:0] count;
  logic       busy;
  logic       ferr;
  logic       perr;
  logic       ovr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .BAUD_DIV   (Baud),
    .DATA_BITS  (8),
    .PARITY     (2),
    .STOP_BITS  (1),
    .FIFO_DEPTH (Depth)
  ) dut (
    .wb_clk       (clk),
    .wb_rst       (rst),
    .i_rx         (rx),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_count      (count),
    .o_busy       (busy),
    .o_frame_err  (ferr),
    .o_parity_err (perr),
    .o_overrun    (ovr),
    .i_clr_err    (clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: start, 8 data LSB first, even parity (optionally inverted), stop.
  // A zero stop bit leaves the line low on return.
  task automatic send(input logic [7:0] d, input logic par_flip, input logic stop_v);
    rx = 1'b0;
    idle(Baud);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(Baud);
    end
    rx = (^d) ^ par_flip;
    idle(Baud);
    rx = stop_v;
    idle(Baud);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    logic saw_busy;
    logic synced;

    // Reset values
    idle(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {29'd0, ferr, perr, ovr}, 32'd0);
    rst = 1'b0;
    idle(Baud);

    // Two clean frames, FWFT order and occupancy
    send(8'h55, 1'b0, 1'b1);
    send(8'hA3, 1'b0, 1'b1);
    idle(Baud);
    chk("two_valid", 32'(valid), 32'd1);
    chk("two_data0", 32'(data), 32'h55);
    chk("two_count2", 32'(count), 32'd2);
    chk("two_flags", {29'd0, ferr, perr, ovr}, 32'd0);
    pop_one();
    chk("two_data1", 32'(data), 32'hA3);
    chk("two_count1", 32'(count), 32'd1);
    pop_one();
    chk("two_count0", 32'(count), 32'd0);
    chk("two_empty", 32'(valid), 32'd0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("pop_empty_ignored", 32'(count), 32'd0);

    // Parity error discards the frame; clear then accept a good one
    send(8'h07, 1'b1, 1'b1);
    idle(Baud);
    chk("par_err_set", 32'(perr), 32'd1);
    chk("par_err_nopush", 32'(count), 32'd0);
    chk("par_err_noferr", 32'(ferr), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("par_err_clr", 32'(perr), 32'd0);
    send(8'h07, 1'b0, 1'b1);
    idle(Baud);
    chk("par_ok_data", 32'(data), 32'h07);
    chk("par_ok_count", 32'(count), 32'd1);
    chk("par_ok_noerr", 32'(perr), 32'd0);
    pop_one();

    // Framing error followed by a held-low line: one break, nothing pushed
    send(8'h41, 1'b0, 1'b0);
    idle(4 * Baud);
    chk("brk_busy", 32'(busy), 32'd1);
    chk("brk_ferr", 32'(ferr), 32'd1);
    chk("brk_nopush", 32'(count), 32'd0);
    rx = 1'b1;
    idle(Baud);
    chk("brk_exit", 32'(busy), 32'd0);
    chk("brk_still_nopush", 32'(count), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("brk_clr", 32'(ferr), 32'd0);
    send(8'h42, 1'b0, 1'b1);
    idle(Baud);
    chk("brk_next_data", 32'(data), 32'h42);
    chk("brk_next_count", 32'(count), 32'd1);
    pop_one();

    // Short glitch: start detected, rejected at mid start bit
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    chk("glitch_busy", 32'(busy), 32'd1);
    idle(20);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_nopush", 32'(count), 32'd0);
    chk("glitch_flags", {29'd0, ferr, perr, ovr}, 32'd0);

    // Overrun: five characters into a four-entry FIFO
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 1'b0, 1'b1);
    idle(Baud);
    chk("ovr_count", 32'(count), 32'd4);
    chk("ovr_flag", 32'(ovr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_drain", 32'(data), 32'h30 + 32'(i));
      pop_one();
    end
    chk("ovr_drained", 32'(count), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr", 32'(ovr), 32'd0);

    // Fill, then pop in exactly the cycle the fifth character is pushed
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 1'b0, 1'b1);
    idle(Baud);
    chk("full_count", 32'(count), 32'd4);
    saw_busy = 1'b0;
    synced = 1'b0;
    fork
      send(8'h34, 1'b0, 1'b1);
      begin
        // Busy drops on the last stop sample; the push lands on the next edge
        for (int c = 0; c < 12 * Baud && !synced; c++) begin
          @(negedge clk);
          if (busy) saw_busy = 1'b1;
          else if (saw_busy) begin
            synced = 1'b1;
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
          end
        end
      end
    join
    chk("pp_synced", 32'(synced), 32'd1);
    idle(Baud);
    chk("pp_no_ovr", 32'(ovr), 32'd0);
    chk("pp_count", 32'(count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      chk("pp_drain", 32'(data), 32'h30 + 32'(i));
      pop_one();
    end
    chk("pp_drained", 32'(count), 32'd0);

    // Reset mid-frame flushes FIFO and aborts the frame
    send(8'h5A, 1'b0, 1'b1);
    idle(Baud);
    chk("pre_rst_count", 32'(count), 32'd1);
    fork
      send(8'h66, 1'b0, 1'b1);
      begin
        idle(3 * Baud);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(valid), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_data", 32'(data), 32'd0);
      end
    join
    rst = 1'b0;
    idle(Baud);
    send(8'h67, 1'b0, 1'b1);
    idle(Baud);
    chk("post_rst_valid", 32'(valid), 32'd1);
    chk("post_rst_data", 32'(data), 32'h67);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_flags", {29'd0, ferr, perr, ovr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
